// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: byte-lane data RAM access, load extension and MEM/WB latch.
// The lane logic assumes a 32-bit data path (four byte lanes).
module mem_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8,
    parameter int NB_REG  = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_stall,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_store_data,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [1:0]         i_width,
    input  logic               i_unsigned,
    input  logic               i_reg_write,
    input  logic               i_mem_to_reg,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_wb_data,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic [NB_REG-1:0]  o_wb_rd,
    output logic               o_reg_write,
    output logic               o_mem_to_reg,
    output logic               o_misaligned,
    output logic [NB_DATA-1:0] o_dbg_data
);
    localparam int NB_LANE = 4;

    logic [NB_DATA-1:0] mem [2**NB_ADDR];

    logic [NB_ADDR-1:0] widx;
    logic [1:0]         off;
    logic               bad_align;
    logic               misaligned;
    logic               we;
    logic [NB_LANE-1:0] be;
    logic [NB_DATA-1:0] wdata;

    logic [NB_DATA-1:0] rdata_q;
    logic [NB_DATA-1:0] dbg_q;
    logic [NB_DATA-1:0] alu_q;
    logic [NB_REG-1:0]  rd_q;
    logic               rw_q, m2r_q, mis_q, ld_q, uns_q;
    logic [1:0]         off_q, width_q;

    logic [7:0]         lane;
    logic [15:0]        half;
    logic [NB_DATA-1:0] wb_d;

    assign widx = i_alu_result[NB_ADDR+1:2];
    assign off  = i_alu_result[1:0];

    always_comb begin
        bad_align = 1'b0;
        be        = '0;
        wdata     = i_store_data;
        case (i_width)
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {NB_LANE{i_store_data[7:0]}};
            end
            2'b01: begin
                bad_align = off[0];
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata     = {(NB_LANE/2){i_store_data[15:0]}};
            end
            2'b11: begin
                bad_align = (off != 2'b00);
                be        = 4'b1111;
            end
            default: bad_align = 1'b1;
        endcase
    end

    assign misaligned = (i_mem_read | i_mem_write) & bad_align;
    assign we         = i_mem_write & ~i_stall & ~i_reset & ~misaligned;

    // Read-first: rdata_q captures the word before this edge's write lands.
    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int b = 0; b < NB_LANE; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (!i_stall) rdata_q <= mem[widx];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) dbg_q <= '0;
        else         dbg_q <= mem[i_dbg_addr];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            alu_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            mis_q   <= 1'b0;
            ld_q    <= 1'b0;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            width_q <= 2'b00;
        end else if (!i_stall) begin
            alu_q   <= i_alu_result;
            rd_q    <= i_rd;
            rw_q    <= i_reg_write & ~(misaligned & i_mem_read);
            m2r_q   <= i_mem_to_reg;
            mis_q   <= misaligned;
            ld_q    <= i_mem_read & ~misaligned;
            uns_q   <= i_unsigned;
            off_q   <= off;
            width_q <= i_width;
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    lane = rdata_q[7:0];
            2'd1:    lane = rdata_q[15:8];
            2'd2:    lane = rdata_q[23:16];
            default: lane = rdata_q[31:24];
        endcase
        half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        wb_d = '0;
        if (ld_q) begin
            case (width_q)
                2'b00:   wb_d = {{(NB_DATA-8){~uns_q & lane[7]}}, lane};
                2'b01:   wb_d = {{(NB_DATA-16){~uns_q & half[15]}}, half};
                default: wb_d = rdata_q;
            endcase
        end
    end

    assign o_wb_data    = wb_d;
    assign o_alu_result = alu_q;
    assign o_wb_rd      = rd_q;
    assign o_reg_write  = rw_q;
    assign o_mem_to_reg = m2r_q;
    assign o_misaligned = mis_q;
    assign o_dbg_data   = dbg_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with directed load/store vectors.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst, stall, mrd, mwr, uns, rw, m2r;
    logic [31:0] alu, sd;
    logic [1:0]  wid;
    logic [4:0]  rd;
    logic [7:0]  dbga;
    logic [31:0] o_wb, o_alu, o_dbg;
    logic [4:0]  o_rd;
    logic        o_rw, o_m2r, o_mis;

    mem_stage dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_alu_result(alu),
        .i_store_data(sd), .i_mem_read(mrd), .i_mem_write(mwr), .i_width(wid),
        .i_unsigned(uns), .i_reg_write(rw), .i_mem_to_reg(m2r), .i_rd(rd),
        .i_dbg_addr(dbga), .o_wb_data(o_wb), .o_alu_result(o_alu), .o_wb_rd(o_rd),
        .o_reg_write(o_rw), .o_mem_to_reg(o_m2r), .o_misaligned(o_mis), .o_dbg_data(o_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] wb, alu, dbg;
        logic [4:0]  rd;
        logic        rw, m2r, mis, chk_dbg;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   cyc = 0;
    int   n_pass = 0, n_total = 0;
    int   op_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Monitor: compare the head entry on the cycle its response is due.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due < cyc) begin
            n_total++;
            $display("FAIL missed_check: got cycle %0d expected cycle %0d", cyc, q[0].due);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("wb_data", o_wb, e.wb);
            chk("alu_result", o_alu, e.alu);
            chk("wb_rd", {27'd0, o_rd}, {27'd0, e.rd});
            chk("reg_write", {31'd0, o_rw}, {31'd0, e.rw});
            chk("mem_to_reg", {31'd0, o_m2r}, {31'd0, e.m2r});
            chk("misaligned", {31'd0, o_mis}, {31'd0, e.mis});
            if (e.chk_dbg) chk("dbg_data", o_dbg, e.dbg);
        end
    end

    // kind: 0 nop, 1 load, 2 store, 3 load+store
    task automatic op(input int kind, input logic [1:0] w, input logic u, input logic [31:0] a,
                      input logic [31:0] d, input logic r_w, input logic [7:0] da,
                      input logic s, input logic r,
                      input logic [31:0] e_wb, input logic e_mis, input logic e_rw,
                      input logic cd, input logic [31:0] e_dbg);
        exp_t e;
        @(posedge clk);
        #1;
        op_id++;
        mrd = kind[0]; mwr = kind[1]; wid = w; uns = u; alu = a; sd = d;
        rw = r_w; m2r = kind[0]; rd = op_id[4:0]; dbga = da; stall = s; rst = r;
        e.due = cyc + 1; e.chk_dbg = cd; e.dbg = e_dbg;
        if (r) begin
            e.wb = 0; e.alu = 0; e.rd = 0; e.rw = 0; e.m2r = 0; e.mis = 0; e.dbg = 0;
        end else if (s) begin
            e.wb = last.wb; e.alu = last.alu; e.rd = last.rd;
            e.rw = last.rw; e.m2r = last.m2r; e.mis = last.mis;
        end else begin
            e.wb = e_wb; e.alu = a; e.rd = op_id[4:0]; e.rw = e_rw; e.m2r = kind[0]; e.mis = e_mis;
        end
        last = e;
        q.push_back(e);
    endtask

    initial begin
        rst = 1; stall = 0; mrd = 0; mwr = 0; wid = 0; uns = 0; alu = 0; sd = 0;
        rw = 0; m2r = 0; rd = 0; dbga = 0;
        repeat (2) @(posedge clk);
        //  kind wid  u  addr       data          rw  dbg   stl rst  e_wb          mis rw  cd  e_dbg
        op(0, 2'b11, 0, 32'h0,     32'h0,         0, 8'd0, 0, 1, 32'h0,         0, 0, 1, 32'h0);
        op(2, 2'b11, 0, 32'h10,    32'hDEADBEEF,  0, 8'd0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
        op(1, 2'b11, 0, 32'h10,    32'h0,         1, 8'd4, 0, 0, 32'hDEADBEEF,  0, 1, 1, 32'hDEADBEEF);
        op(2, 2'b11, 0, 32'h20,    32'h11223344,  0, 8'd8, 0, 0, 32'h0,         0, 0, 0, 32'h0);
        op(2, 2'b00, 0, 32'h21,    32'h123456AA,  0, 8'd8, 0, 0, 32'h0,         0, 0, 1, 32'h11223344);
        op(1, 2'b00, 0, 32'h21,    32'h0,         1, 8'd8, 0, 0, 32'hFFFFFFAA,  0, 1, 1, 32'h1122AA44);
        op(1, 2'b00, 1, 32'h21,    32'h0,         1, 8'd8, 0, 0, 32'h000000AA,  0, 1, 1, 32'h1122AA44);
        op(2, 2'b11, 0, 32'h30,    32'h80017FFF,  0, 8'd12, 0, 0, 32'h0,        0, 0, 0, 32'h0);
        op(1, 2'b01, 0, 32'h32,    32'h0,         1, 8'd12, 0, 0, 32'hFFFF8001, 0, 1, 1, 32'h80017FFF);
        op(1, 2'b01, 1, 32'h32,    32'h0,         1, 8'd12, 0, 0, 32'h00008001, 0, 1, 1, 32'h80017FFF);
        op(1, 2'b01, 0, 32'h30,    32'h0,         1, 8'd12, 0, 0, 32'h00007FFF, 0, 1, 1, 32'h80017FFF);
        op(1, 2'b11, 0, 32'h31,    32'h0,         1, 8'd12, 0, 0, 32'h0,        1, 0, 1, 32'h80017FFF);
        op(2, 2'b01, 0, 32'h33,    32'h0000BEEF,  0, 8'd12, 0, 0, 32'h0,        1, 0, 1, 32'h80017FFF);
        op(0, 2'b11, 0, 32'h7,     32'h0,         1, 8'd12, 0, 0, 32'h0,        0, 1, 1, 32'h80017FFF);
        op(1, 2'b10, 0, 32'h30,    32'h0,         1, 8'd12, 0, 0, 32'h0,        1, 0, 1, 32'h80017FFF);
        op(2, 2'b11, 0, 32'h40,    32'h0,         0, 8'd16, 0, 0, 32'h0,        0, 0, 0, 32'h0);
        op(1, 2'b11, 0, 32'h10,    32'h0,         1, 8'd16, 0, 0, 32'hDEADBEEF, 0, 1, 1, 32'h0);
        op(2, 2'b11, 0, 32'h40,    32'h55,        0, 8'd16, 1, 0, 32'h0,        0, 0, 1, 32'h0);
        op(2, 2'b11, 0, 32'h40,    32'h55,        0, 8'd16, 1, 0, 32'h0,        0, 0, 1, 32'h0);
        op(1, 2'b11, 0, 32'h40,    32'h0,         1, 8'd16, 0, 0, 32'h0,        0, 1, 1, 32'h0);
        op(2, 2'b11, 0, 32'h50,    32'hCAFEF00D,  0, 8'd20, 0, 0, 32'h0,        0, 0, 0, 32'h0);
        op(2, 2'b11, 0, 32'h50,    32'h1234,      1, 8'd20, 0, 1, 32'h0,        0, 0, 1, 32'h0);
        op(1, 2'b11, 0, 32'h50,    32'h0,         1, 8'd20, 0, 0, 32'hCAFEF00D, 0, 1, 1, 32'hCAFEF00D);
        op(2, 2'b11, 0, 32'h400,   32'h0BADC0DE,  0, 8'd0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
        op(1, 2'b11, 0, 32'h0,     32'h0,         1, 8'd0, 0, 0, 32'h0BADC0DE,  0, 1, 1, 32'h0BADC0DE);
        op(3, 2'b11, 0, 32'h10,    32'h01020304,  1, 8'd4, 0, 0, 32'hDEADBEEF,  0, 1, 1, 32'hDEADBEEF);
        op(1, 2'b11, 0, 32'h10,    32'h0,         1, 8'd4, 0, 0, 32'h01020304,  0, 1, 1, 32'h01020304);
        @(posedge clk);
        #1;
        mrd = 0; mwr = 0; stall = 0; rst = 0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got time limit expected finish");
        $fatal(1);
    end
endmodule
